// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   calc_aw()            : address width for a given register count
//   reg_addr_t / xlen_t  : address and data types at the default sizes
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Address width; never below one bit so a 2-entry file still has an address.
  function automatic int calc_aw(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

  typedef logic [calc_aw(NREGS_DEF)-1:0] reg_addr_t;
  typedef logic [XLEN_DEF-1:0]           xlen_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between the decode/writeback logic and the register file.
//   wr_en/wr_addr/wr_data : NUM_WR write ports
//   rd_addr/rd_data       : NUM_RD combinational read ports
//   rd_busy               : per read port, addressed register has a pending producer
//   rsv_en/rsv_addr       : reserve a destination register
//   busy_vec              : registered scoreboard bits
// master = issue/writeback side, slave = register file.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
);
  localparam int AW = calc_aw(NREGS);

  logic [NUM_WR-1:0]           wr_en;
  logic [NUM_WR-1:0][AW-1:0]   wr_addr;
  logic [NUM_WR-1:0][XLEN-1:0] wr_data;
  logic [NUM_RD-1:0][AW-1:0]   rd_addr;
  logic [NUM_RD-1:0][XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]           rd_busy;
  logic                        rsv_en;
  logic [AW-1:0]               rsv_addr;
  logic [NREGS-1:0]            busy_vec;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy_vec
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits.
//   clk, reset_n : clock and synchronous active-low reset
//   rsv_en/addr  : sets the busy bit of the reserved register
//   clr_en/addr  : one clear per write port (already filtered for dropped writes)
//   busy_vec     : registered busy state
// A reservation beats a clear on the same register: the new producer owns it.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = calc_aw(NREGS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      rsv_en,
  input  logic [AW-1:0]             rsv_addr,
  input  logic [NUM_WR-1:0]         clr_en,
  input  logic [NUM_WR-1:0][AW-1:0] clr_addr,
  output logic [NREGS-1:0]          busy_vec
);

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_bit
    logic clr_c;

    always_comb begin
      clr_c = 1'b0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (clr_en[w] && (clr_addr[w] == AW'(gi))) clr_c = 1'b1;
      end
    end

    assign clr_vec[gi] = clr_c;
    // Register 0 can never become busy when it is hardwired.
    assign set_vec[gi] = rsv_en && (rsv_addr == AW'(gi)) &&
                         !((ZERO_REG != 0) && (gi == 0));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) busy_reg <= '0;
    else          busy_reg <= set_vec | (busy_reg & ~clr_vec);
  end

  assign busy_vec = busy_reg;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with scoreboard.
//   clk, reset_n : clock and synchronous active-low reset
//   bus          : regfile_mp_if slave (write ports, read ports, reservation, busy)
// Reads are combinational; optional bypass forwards same-cycle write data and
// masks the busy flag for that read. On write-address collisions the highest
// write port index wins, both for storage and for forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         reset_n,
  regfile_mp_if.slave bus
);

  localparam int AW = calc_aw(NREGS);

  logic [XLEN-1:0]   mem_reg [NREGS];
  logic [NUM_WR-1:0] wr_ok;
  logic [NREGS-1:0]  busy_w;

  // A write is effective unless it targets a hardwired register 0.
  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr
    assign wr_ok[gi] = bus.wr_en[gi] &&
                       !((ZERO_REG != 0) && (bus.wr_addr[gi] == '0));
  end

  // Ascending loop: later (higher-index) ports overwrite earlier ones.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) mem_reg[r] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w]) mem_reg[bus.wr_addr[w]] <= bus.wr_data[w];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS   (NREGS),
    .NUM_WR  (NUM_WR),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk     (clk),
    .reset_n (reset_n),
    .rsv_en  (bus.rsv_en),
    .rsv_addr(bus.rsv_addr),
    .clr_en  (wr_ok),
    .clr_addr(bus.wr_addr),
    .busy_vec(busy_w)
  );

  assign bus.busy_vec = busy_w;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [XLEN-1:0] data_c;
    logic            hit_c;
    logic            zero_c;

    always_comb begin
      data_c = mem_reg[bus.rd_addr[gi]];
      hit_c  = 1'b0;
      zero_c = (ZERO_REG != 0) && (bus.rd_addr[gi] == '0);
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_ok[w] && (bus.wr_addr[w] == bus.rd_addr[gi])) begin
            data_c = bus.wr_data[w];
            hit_c  = 1'b1;
          end
        end
      end
      if (zero_c) data_c = '0;
    end

    assign bus.rd_data[gi] = data_c;
    // A forwarded write satisfies the pending producer, so busy is hidden.
    assign bus.rd_busy[gi] = busy_w[bus.rd_addr[gi]] && !hit_c && !zero_c;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with two configurations side by side:
//   dut_a: 4 read, 2 write ports, bypass on, register 0 hardwired
//   dut_b: 2 read, 1 write port, bypass off, register 0 writable
// Expected values are queued when stimulus is driven and popped at each check.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NUM_RD(4), .NUM_WR(2)) ifa ();
  regfile_mp_if #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(1)) ifb ();

  regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(4), .NUM_WR(2),
               .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa));

  regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(1),
               .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb));

  typedef struct {
    string        tag;
    logic [127:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic push(input string tag, input logic [127:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb_q.push_back(x);
  endtask

  task automatic check(input logic [127:0] obs);
    exp_t x;
    n_assert++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty observed=%h required=<queued value>", obs);
      return;
    end
    x = sb_q.pop_front();
    $display("check %-22s observed=%h expected=%h", x.tag, obs, x.exp);
    assert (obs === x.exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
    end
  endtask

  task automatic idle();
    ifa.wr_en = '0; ifa.wr_addr = '0; ifa.wr_data = '0;
    ifa.rsv_en = 1'b0; ifa.rsv_addr = '0; ifa.rd_addr = '0;
    ifb.wr_en = '0; ifb.wr_addr = '0; ifb.wr_data = '0;
    ifb.rsv_en = 1'b0; ifb.rsv_addr = '0; ifb.rd_addr = '0;
  endtask

  // Drive at the falling edge, sample 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    step();
    // Reset state
    push("rst_a_rd_data", 128'd0); push("rst_a_busy_vec", 128'd0);
    push("rst_a_rd_busy", 128'd0); push("rst_b_rd_data", 128'd0);
    push("rst_b_busy_vec", 128'd0);
    #1;
    check(ifa.rd_data); check(ifa.busy_vec); check(ifa.rd_busy);
    check(ifb.rd_data); check(ifb.busy_vec);
    reset_n = 1'b1;

    // Write x5, read it back, then reset with a pending write/reservation
    step(); idle();
    ifa.wr_en[0] = 1'b1; ifa.wr_addr[0] = 5'd5; ifa.wr_data[0] = 32'hDEADBEEF;
    step(); idle();
    ifa.rd_addr[0] = 5'd5;
    push("x5_before_reset", 128'hDEADBEEF);
    #1 check(ifa.rd_data[0]);
    reset_n = 1'b0;
    ifa.wr_en[0] = 1'b1; ifa.wr_addr[0] = 5'd5; ifa.wr_data[0] = 32'h1;
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd6;
    step(); reset_n = 1'b1; idle();
    ifa.rd_addr[0] = 5'd5;
    push("x5_after_reset", 128'd0); push("busy_after_reset", 128'd0);
    #1 check(ifa.rd_data[0]); check(ifa.busy_vec);

    // Register 0: hardwired on A, writable on B
    step(); idle();
    ifa.wr_en[0] = 1'b1; ifa.wr_addr[0] = 5'd0; ifa.wr_data[0] = 32'h1234;
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd0;
    ifb.wr_en[0] = 1'b1; ifb.wr_addr[0] = 5'd0; ifb.wr_data[0] = 32'h1234;
    push("a_x0_bypass_data", 128'd0); push("a_x0_bypass_busy", 128'd0);
    #1 check(ifa.rd_data[0]); check(ifa.rd_busy[0]);
    step(); idle();
    push("a_x0_data", 128'd0); push("a_x0_busy", 128'd0);
    push("a_x0_busy_vec", 128'd0); push("b_x0_data", 128'h1234);
    #1 check(ifa.rd_data[0]); check(ifa.rd_busy[0]); check(ifa.busy_vec);
    check(ifb.rd_data[0]);

    // Bypass: same-cycle forward on A, one cycle later on B
    step(); idle();
    ifa.wr_en[0] = 1'b1; ifa.wr_addr[0] = 5'd7; ifa.wr_data[0] = 32'hA5A5A5A5;
    ifa.rd_addr[1] = 5'd7;
    ifb.wr_en[0] = 1'b1; ifb.wr_addr[0] = 5'd7; ifb.wr_data[0] = 32'hA5A5A5A5;
    ifb.rd_addr[1] = 5'd7;
    push("a_bypass_x7", 128'hA5A5A5A5); push("b_nobypass_x7", 128'd0);
    #1 check(ifa.rd_data[1]); check(ifb.rd_data[1]);
    step(); idle();
    ifb.rd_addr[1] = 5'd7;
    push("b_x7_next", 128'hA5A5A5A5);
    #1 check(ifb.rd_data[1]);

    // Write conflict on A: port 1 wins
    step(); idle();
    ifa.wr_en = 2'b11;
    ifa.wr_addr[0] = 5'd3; ifa.wr_data[0] = 32'h11;
    ifa.wr_addr[1] = 5'd3; ifa.wr_data[1] = 32'h22;
    ifa.rd_addr[2] = 5'd3;
    push("conflict_bypass", 128'h22);
    #1 check(ifa.rd_data[2]);
    step(); idle();
    ifa.rd_addr[2] = 5'd3;
    push("conflict_stored", 128'h22);
    #1 check(ifa.rd_data[2]);

    // Scoreboard: reserve x9
    step(); idle();
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd9; ifa.rd_addr[0] = 5'd9;
    ifb.rsv_en = 1'b1; ifb.rsv_addr = 5'd9; ifb.rd_addr[0] = 5'd9;
    push("a_rsv_same_cycle", 128'd0);
    #1 check(ifa.rd_busy[0]);
    step(); idle();
    ifa.rd_addr[0] = 5'd9; ifb.rd_addr[0] = 5'd9;
    push("a_rsv_busy", 128'd1); push("a_rsv_busy_vec", 128'h200);
    push("b_rsv_busy", 128'd1);
    #1 check(ifa.rd_busy[0]); check(ifa.busy_vec); check(ifb.rd_busy[0]);
    // Write x9: A clears busy this cycle, B next cycle
    ifa.wr_en[0] = 1'b1; ifa.wr_addr[0] = 5'd9; ifa.wr_data[0] = 32'h55;
    ifb.wr_en[0] = 1'b1; ifb.wr_addr[0] = 5'd9; ifb.wr_data[0] = 32'h55;
    push("a_wr_busy_masked", 128'd0); push("a_wr_data_fwd", 128'h55);
    push("a_wr_busy_vec_reg", 128'h200); push("b_wr_busy_still", 128'd1);
    push("b_wr_data_old", 128'd0);
    #1 check(ifa.rd_busy[0]); check(ifa.rd_data[0]); check(ifa.busy_vec);
    check(ifb.rd_busy[0]); check(ifb.rd_data[0]);
    step(); idle();
    ifa.rd_addr[0] = 5'd9; ifb.rd_addr[0] = 5'd9;
    push("a_busy_vec_clear", 128'd0); push("b_busy_clear", 128'd0);
    push("b_data_x9", 128'h55);
    #1 check(ifa.busy_vec); check(ifb.rd_busy[0]); check(ifb.rd_data[0]);
    // Reserve and write x9 together: reservation wins
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd9;
    ifa.wr_en[0] = 1'b1; ifa.wr_addr[0] = 5'd9; ifa.wr_data[0] = 32'h66;
    ifb.rsv_en = 1'b1; ifb.rsv_addr = 5'd9;
    ifb.wr_en[0] = 1'b1; ifb.wr_addr[0] = 5'd9; ifb.wr_data[0] = 32'h66;
    step(); idle();
    ifa.rd_addr[0] = 5'd9;
    push("a_rsv_wr_busy_vec", 128'h200); push("b_rsv_wr_busy_vec", 128'h200);
    push("a_rsv_wr_rd_busy", 128'd1); push("a_rsv_wr_data", 128'h66);
    #1 check(ifa.busy_vec); check(ifb.busy_vec); check(ifa.rd_busy[0]);
    check(ifa.rd_data[0]);

    // Multi-port read on A (port 1 write to x0 is dropped)
    step(); idle();
    ifa.wr_en = 2'b11;
    ifa.wr_addr[0] = 5'd1; ifa.wr_data[0] = 32'd1;
    ifa.wr_addr[1] = 5'd2; ifa.wr_data[1] = 32'd2;
    step(); idle();
    ifa.wr_en = 2'b11;
    ifa.wr_addr[0] = 5'd31; ifa.wr_data[0] = 32'd31;
    ifa.wr_addr[1] = 5'd0;  ifa.wr_data[1] = 32'hFFFF;
    step(); idle();
    ifa.rd_addr[0] = 5'd1; ifa.rd_addr[1] = 5'd2;
    ifa.rd_addr[2] = 5'd0; ifa.rd_addr[3] = 5'd31;
    push("multi_read", {32'd31, 32'd0, 32'd2, 32'd1});
    #1 check(ifa.rd_data);

    // Reset mid-operation with a pending reservation
    reset_n = 1'b0;
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd10;
    step(); reset_n = 1'b1; idle();
    ifa.rd_addr[3] = 5'd31;
    push("mid_reset_busy_vec", 128'd0); push("mid_reset_x31", 128'd0);
    #1 check(ifa.busy_vec); check(ifa.rd_data[3]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=end of sequence");
    $fatal(1, "watchdog");
  end

endmodule
